// File: rtl/aes_key_schedule_seq_if.sv
// Stream/handshake bundle between the key register, aes_key_schedule_seq and the cipher core.
interface aes_key_schedule_seq_if #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_W         = 128
);
    logic                    start;
    logic [1:0]              key_len;
    logic [MAX_KEY_BITS-1:0] key_in;
    logic                    start_rev;
    logic                    ready;
    logic                    busy;
    logic [RK_W-1:0]         rk_out;
    logic [3:0]              rk_round;
    logic                    rk_valid;
    logic                    rk_ready;
    logic                    rk_last;

    modport master (output start, key_len, key_in, start_rev, rk_ready,
                    input  ready, busy, rk_out, rk_round, rk_valid, rk_last);
    modport slave  (input  start, key_len, key_in, start_rev, rk_ready,
                    output ready, busy, rk_out, rk_round, rk_valid, rk_last);
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule, one word per clock through one shared 4-byte S-box.
// Optional reverse (decryption-order) replay store enabled by defining KEYSCHED_REVERSE_EN.
module aes_key_schedule_seq #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RK_W         = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_key_schedule_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GEN, DRAIN, REPLAY} state_t;

    state_t                  state, state_nxt;
    logic [MAX_KEY_BITS-1:0] key_sh;
    logic [31:0]             win [8];
    logic [31:0]             acc [3];
    logic [5:0]              widx;
    logic [2:0]              mcnt;
    logic [3:0]              nk, nr, len_nk, len_nr;
    logic [7:0]              rcon;
    logic [RK_W-1:0]         rk_out_q;
    logic [3:0]              rk_round_q;
    logic                    rk_valid_q, rk_last_q;
    logic                    start_acc, out_free, beat, group_done, last_word;
    logic                    is_key, advance, load_gen;
    logic [31:0]             prev_w, far_w, sub_in, sub_out, temp, new_w;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Key lengths wider than the instance supports fall back to 128.
    always_comb begin
        len_nk = 4'd4;
        len_nr = 4'd10;
        if (bus.key_len == 2'b01 && MAX_KEY_BITS >= 192) begin
            len_nk = 4'd6;
            len_nr = 4'd12;
        end else if (bus.key_len == 2'b10 && MAX_KEY_BITS >= 256) begin
            len_nk = 4'd8;
            len_nr = 4'd14;
        end
    end

    assign start_acc  = (state == IDLE) && bus.start;
    assign out_free   = !rk_valid_q || bus.rk_ready;
    assign beat       = rk_valid_q && bus.rk_ready;
    assign group_done = (widx[1:0] == 2'd3);
    assign last_word  = (widx == {nr, 2'b11});
    assign is_key     = (widx < {2'b00, nk});
    // A completed group stalls generation until the output register can take it.
    assign advance    = (state == GEN) && (!group_done || out_free);
    assign load_gen   = advance && group_done;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        prev_w  = win[0];
        far_w   = win[3'(nk - 4'd1)];
        sub_in  = (mcnt == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out = subword(sub_in);
        temp    = prev_w;
        if (mcnt == 3'd0)
            temp = sub_out ^ {rcon, 24'h000000};
        else if (nk == 4'd8 && mcnt == 3'd4)
            temp = sub_out;
        new_w = is_key ? key_sh[MAX_KEY_BITS-1 -: 32] : (far_w ^ temp);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef KEYSCHED_REVERSE_EN
    logic [RK_W-1:0] store [15];
    logic [3:0]      rp;
    logic            rp_done, sched_ok, rev_acc, load_rev;

    assign rev_acc  = (state == IDLE) && !bus.start && bus.start_rev && sched_ok;
    assign load_rev = (state == REPLAY) && !rp_done && out_free;

    // NOTE: the round-key store is plain RAM with no reset; sched_ok guards its contents.
    always_ff @(posedge clk) begin
        if (load_gen) store[widx[5:2]] <= {acc[0], acc[1], acc[2], new_w};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp       <= 4'd0;
            rp_done  <= 1'b0;
            sched_ok <= 1'b0;
        end else begin
            if (start_acc)
                sched_ok <= 1'b0;
            else if (state == DRAIN && beat)
                sched_ok <= 1'b1;
            if (rev_acc) begin
                rp      <= nr;
                rp_done <= 1'b0;
            end else if (load_rev) begin
                if (rp == 4'd0) rp_done <= 1'b1;
                else            rp      <= rp - 4'd1;
            end
        end
    end
`else
    logic unused_start_rev;
    assign unused_start_rev = bus.start_rev;
`endif

    always_comb begin
        state_nxt = state;
        bus.ready = (state == IDLE);
        bus.busy  = (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = GEN;
`ifdef KEYSCHED_REVERSE_EN
                else if (rev_acc) state_nxt = REPLAY;
`endif
            end
            GEN:     if (advance && last_word) state_nxt = DRAIN;
            DRAIN:   if (beat) state_nxt = IDLE;
            REPLAY:  if (beat && rk_last_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_sh <= '0;
            widx   <= 6'd0;
            mcnt   <= 3'd0;
            nk     <= 4'd4;
            nr     <= 4'd10;
            rcon   <= 8'h01;
            for (int k = 0; k < 8; k++) win[k] <= '0;
            for (int k = 0; k < 3; k++) acc[k] <= '0;
        end else if (start_acc) begin
            key_sh <= bus.key_in;
            widx   <= 6'd0;
            mcnt   <= 3'd0;
            nk     <= len_nk;
            nr     <= len_nr;
            rcon   <= 8'h01;
        end else if (advance) begin
            win[0] <= new_w;
            for (int k = 1; k < 8; k++) win[k] <= win[k-1];
            case (widx[1:0])
                2'd0:    acc[0] <= new_w;
                2'd1:    acc[1] <= new_w;
                2'd2:    acc[2] <= new_w;
                default: ;
            endcase
            widx <= widx + 6'd1;
            mcnt <= (mcnt == 3'(nk - 4'd1)) ? 3'd0 : mcnt + 3'd1;
            if (is_key)
                key_sh <= key_sh << 32;
            else if (mcnt == 3'd0)
                rcon <= xtime(rcon);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out_q   <= '0;
            rk_round_q <= 4'd0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
        end else if (load_gen) begin
            rk_out_q   <= {acc[0], acc[1], acc[2], new_w};
            rk_round_q <= widx[5:2];
            rk_valid_q <= 1'b1;
            rk_last_q  <= last_word;
`ifdef KEYSCHED_REVERSE_EN
        end else if (load_rev) begin
            rk_out_q   <= store[rp];
            rk_round_q <= rp;
            rk_valid_q <= 1'b1;
            rk_last_q  <= (rp == 4'd0);
`endif
        end else if (beat) begin
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
        end
    end

    assign bus.rk_out   = rk_out_q;
    assign bus.rk_round = rk_round_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_last  = rk_last_q;
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed, table-driven bench for aes_key_schedule_seq using the FIPS-197 expansion vectors.
module tb_aes_key_schedule_seq;
    localparam int MKB = 256;

    typedef struct {
        logic [1:0]   key_len;
        logic [255:0] key;
        int           beats;
        logic [127:0] r0;
        logic [127:0] rlast;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    vec_t         vecs [4];
    logic [127:0] exp128 [11];
    logic [127:0] got_key [16];
    int           got_round [16];
    int           got_edge [16];
    bit           got_last [16];
    int           nbeat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_key_schedule_seq_if #(.MAX_KEY_BITS(MKB)) bus ();
    aes_key_schedule_seq #(.MAX_KEY_BITS(MKB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Runs one schedule; bp_pct = percent of cycles with rk_ready low, abort_at = edge that sees rst.
    task automatic run(input vec_t v, input int bp_pct, input int abort_at, input bit poke);
        int           e;
        bit           done, aborted, stalled;
        logic [255:0] snap, now_v;
        nbeat   = 0;
        done    = 0;
        aborted = 0;
        stalled = 0;
        snap    = '0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.key_len = v.key_len;
        bus.key_in  = v.key;
        @(posedge clk);
        e = 0;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.key_len = 2'b10;
        bus.key_in  = '1;
        check("busy_after_start", {bus.busy, bus.ready}, 2'b10);
        while (!done && e < 400) begin
            if (abort_at != 0 && e == abort_at) begin
                check("abort_valid_ready", {bus.rk_valid, bus.ready}, 2'b01);
                rst     = 1'b0;
                done    = 1;
                aborted = 1;
            end else begin
                now_v = {122'd0, bus.rk_valid, bus.rk_last, bus.rk_round, bus.rk_out};
                if (stalled) check("stall_hold", now_v, snap);
                bus.rk_ready = (bp_pct == 0) || ($urandom_range(99) >= bp_pct);
                bus.start    = poke && (e == 10);
                if (abort_at != 0 && e == abort_at - 1) rst = 1'b1;
                if (bus.rk_valid && bus.rk_ready) begin
                    if (nbeat < 16) begin
                        got_key[nbeat]   = bus.rk_out;
                        got_round[nbeat] = int'(bus.rk_round);
                        got_edge[nbeat]  = e;
                        got_last[nbeat]  = bus.rk_last;
                    end
                    nbeat++;
                    if (bus.rk_last) done = 1;
                end
                stalled = bus.rk_valid && !bus.rk_ready;
                snap    = now_v;
                @(posedge clk);
                e++;
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        check("run_terminated", done, 1'b1);
        if (done && !aborted)
            check("idle_after_last", {bus.ready, bus.busy, bus.rk_valid}, 3'b100);
    endtask

    task automatic check_seq128(input string tag);
        check({tag, "_beats"}, nbeat, 11);
        for (int k = 0; k < 11 && k < nbeat; k++) begin
            check($sformatf("%s_key%0d", tag, k), got_key[k], exp128[k]);
            check($sformatf("%s_round%0d", tag, k), got_round[k], k);
            check($sformatf("%s_last%0d", tag, k), got_last[k], k == 10);
        end
    endtask

    task automatic replay_run(input bit expect_run);
        int e, nb;
        bit done;
        @(negedge clk);
        bus.start_rev = 1'b1;
        bus.rk_ready  = 1'b1;
        @(posedge clk);
        e = 0;
        @(negedge clk);
        bus.start_rev = 1'b0;
        if (!expect_run) begin
            repeat (3) @(negedge clk);
            check("rev_ignored", {bus.rk_valid, bus.ready}, 2'b01);
            return;
        end
        nb   = 0;
        done = 0;
        while (!done && e < 100) begin
            if (bus.rk_valid) begin
                check($sformatf("rev_key%0d", nb), bus.rk_out, (nb <= 10) ? exp128[10 - nb] : 128'd0);
                check($sformatf("rev_round%0d", nb), bus.rk_round, 10 - nb);
                check($sformatf("rev_edge%0d", nb), e, nb + 1);
                check($sformatf("rev_last%0d", nb), bus.rk_last, nb == 10);
                if (bus.rk_last) done = 1;
                nb++;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        check("rev_beats", nb, 11);
        check("rev_idle_after", {bus.ready, bus.rk_valid}, 2'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        exp128 = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                   128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                   128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                   128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                   128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[0] = '{2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 11,
                    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'd0}, 13,
                    128'h8e73b0f7da0e6452c810f32b809079e5, 128'he98ba06f448c773c8ecc720401002202};
        vecs[2] = '{2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 15,
                    128'h603deb1015ca71be2b73aef0857d7781, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[3] = '{2'b11, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef}, 11,
                    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.start_rev = 1'b0;
        bus.key_len   = 2'b00;
        bus.key_in    = '0;
        bus.rk_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {bus.ready, bus.busy, bus.rk_valid, bus.rk_last}, 4'b1000);
        check("reset_rk_out", bus.rk_out, 128'd0);
        check("reset_rk_round", bus.rk_round, 4'd0);
        rst = 1'b0;

        // Full-rate runs: round r must appear at edge 4(r+1).
        for (int v = 0; v < 4; v++) begin
            run(vecs[v], 0, 0, 0);
            check($sformatf("v%0d_beats", v), nbeat, vecs[v].beats);
            for (int k = 0; k < vecs[v].beats && k < nbeat; k++) begin
                check($sformatf("v%0d_round%0d", v, k), got_round[k], k);
                check($sformatf("v%0d_edge%0d", v, k), got_edge[k], 4 * (k + 1));
                check($sformatf("v%0d_last%0d", v, k), got_last[k], k == vecs[v].beats - 1);
            end
            check($sformatf("v%0d_r0", v), got_key[0], vecs[v].r0);
            check($sformatf("v%0d_rlast", v), got_key[vecs[v].beats - 1], vecs[v].rlast);
            if (vecs[v].beats == 11) check_seq128($sformatf("v%0d", v));
        end

        // Random backpressure with an ignored start pulse mid-run.
        run(vecs[0], 30, 0, 1);
        check_seq128("bp");

        // Reset lands at edge 20 of a 256 run, then a clean 128 run.
        run(vecs[2], 0, 20, 0);
        check("abort_beats_before_rst", nbeat, 4);
        run(vecs[0], 0, 0, 0);
        check_seq128("post_abort");
        for (int k = 0; k < 11 && k < nbeat; k++)
            check($sformatf("post_abort_edge%0d", k), got_edge[k], 4 * (k + 1));

`ifdef KEYSCHED_REVERSE_EN
        replay_run(1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        replay_run(1'b0);
`else
        replay_run(1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule_seq.md
Name: aes_key_schedule_seq

Overview:
Sequential AES key schedule supporting 128/192/256-bit keys, selected per run. Produces one 32-bit schedule word per clock through a single shared 4-byte S-box (team subBytes, 32-bit word form). Emits 128-bit round keys 0..Nr over a valid/ready stream. Sits between the key register and the iterative cipher core, replacing the fixed 128-bit, fully unrolled combinational expansion.

Parameters:
MAX_KEY_BITS, 256, widest key supported (128, 192 or 256); sets key_in width; larger key_len requests clamp to 128
RK_W, 128, round-key output width (fixed by AES; not to be overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin schedule; accepted when start && ready
key_len  in  2  00=128, 01=192, 10=256, 11=treated as 128
key_in  in  MAX_KEY_BITS  cipher key, MSB-aligned (word 0 = key_in[MAX_KEY_BITS-1 -: 32])
ready  out  1  idle, can accept start
busy  out  1  schedule in progress
rk_out  out  128  round key, word 0 in [127:96]
rk_round  out  4  round index of rk_out (0..Nr)
rk_valid  out  1  rk_out valid
rk_ready  in  1  consumer accepts rk_out when rk_valid && rk_ready
rk_last  out  1  high with rk_valid when rk_round == Nr
start_rev  in  1  reverse replay request (see Optional Feature)

Behaviour:
- Reset: ready=1, busy=0, rk_valid=0, rk_last=0, rk_out=0, rk_round=0; FSM to IDLE; counters and window cleared. rst mid-run aborts immediately, no further round keys.
- Latched at accept: Nk=4/6/8, Nr=10/12/14, total words T=4*(Nr+1)=44/52/60. key_len and key_in ignored afterwards.
- FSM: IDLE -(start&&ready)-> GEN -(word T-1 appended)-> DRAIN -(last beat accepted)-> IDLE. start while busy is ignored.
- GEN: one word per cycle, index i=0..T-1. i<Nk: key word i. i>=Nk: temp=w[i-1]; if i mod Nk==0, temp=SubWord(RotWord(temp))^{rcon,24'h0}; else if Nk==8 && i mod Nk==4, temp=SubWord(temp); w[i]=w[i-Nk]^temp.
- Window: 8x32 shift register of most recent words; i mod Nk held in a counter (no divider). rcon register starts 8'h01, advances by xtime (x<<1, ^8'h1b on carry) after each use; 128-bit sequence ends at 8'h36.
- Packing: words accumulate 4 at a time; a full group moves to the output register if it is empty or consumed in the same cycle, else GEN stalls (no word lost or duplicated, window frozen).
- Latency, no backpressure: start accepted at edge 0; round key r first valid at edge 4(r+1); rk_last (round Nr) at edge 44/52/60.
- rk_out, rk_round, rk_last held stable while rk_valid && !rk_ready.
- ready returns high the cycle after the last beat is accepted; busy = !ready.

Optional Feature:
KEYSCHED_REVERSE_EN
- Defined: each emitted round key also written to an internal 15x128 store; sched_ok flag set when a full schedule completes, cleared by rst or any new start. start_rev && ready && sched_ok replays the stored schedule rounds Nr..0 (decryption order) at one beat per accepted cycle; first beat valid at edge 1; rk_last flags round 0. start_rev with sched_ok=0 is ignored. start and start_rev in the same cycle: start wins.
- Not defined: no store; start_rev ignored, port kept for interface stability.

Test Plan:
- 128: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round1 a0fafe1788542cb123a339392a6c7605 at edge 8; round10 d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last at edge 44.
- 192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 beats, round12 e98ba06f448c773c8ecc720401002202, rk_last at edge 52.
- 256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 beats, round14 fe4890d1e6188d0b046df344706c631e.
- Backpressure: 128 vector, rk_ready random 30% -> identical 11-key sequence, rk_out stable while stalled, no gaps/duplicates.
- rst asserted at edge 20 of a 256 run -> next cycle rk_valid=0, ready=1; new 128 run then matches vector 1 exactly. start during busy ignored.
- KEYSCHED_REVERSE_EN: after 128 run, start_rev -> first beat d014f9a8...0ca6 (round10) at edge 1, last beat 2b7e1516...4f3c with rk_last; start_rev after rst ignored.
